tea_out_serializer: RTL
=======================

// Module: tea_out_serializer
// PURPOSE
// - Downstream stage of the TEA cipher core: captures the 2x32-bit result (v0, v1) when the core pulses done.
// - Streams the result out as bytes over a valid/ready handshake to the byte sink (UART TX / host FIFO).
// - Holds one block at a time; a new done while still sending is dropped and flagged.
// PARAMETERS
// - WORD_W     32  width of v0/v1; must be a multiple of 8
// - MSB_FIRST  1   1: each word sent most-significant byte first; 0: least-significant byte first
// PORTS
// - clk       in   1        system clock; all logic on rising edge
// - reset     in   1        synchronous, active-high reset
// - done      in   1        one-cycle pulse from cipher core: v0_in/v1_in valid this cycle
// - v0_in     in   WORD_W   result word 0
// - v1_in     in   WORD_W   result word 1
// - tx_data   out  8        current byte
// - tx_valid  out  1        tx_data valid
// - tx_ready  in   1        sink accepts byte when tx_valid && tx_ready
// - busy      out  1        block captured and not yet fully sent
// - overrun   out  1        sticky: a done arrived while busy; cleared only by reset
// BEHAVIOUR
// - Reset (sync, active-high, priority over everything): state=IDLE; tx_valid=0, tx_data=0, busy=0, overrun=0,
//   shift reg and byte counter cleared. Reset mid-transfer aborts the block; tx_valid low after that edge.
// - States: IDLE -> SEND on done; SEND -> IDLE on handshake of last data byte (or -> CSUM if checksum enabled);
//   CSUM -> IDLE on its handshake.
// - Capture: done in IDLE loads {v0_in, v1_in} into 2*WORD_W shift reg, counter = 2*WORD_W/8.
//   Latency: done at edge N -> tx_valid=1, busy=1, first byte on tx_data from edge N+1.
// - Byte order: all v0 bytes, then all v1 bytes; within each word per MSB_FIRST.
// - Handshake: tx_data and tx_valid held stable while tx_valid && !tx_ready; on transfer, next byte appears the
//   following cycle with tx_valid kept high (back-to-back: 1 byte/cycle when tx_ready held high).
// - tx_valid never depends combinationally on tx_ready.
// - End: after last transfer, tx_valid=0 and busy=0 on the next edge; a new done is accepted from that cycle on.
// - Overrun: done while busy (including the cycle of the final handshake) is ignored, data unchanged,
//   overrun set to 1 on the next edge.
// - done and reset in the same cycle: reset wins, nothing captured.
// - tx_data drives 0 when tx_valid=0.
// CONFIGURATION
// - TEA_SER_CHECKSUM_EN defined: after the last data byte, one extra byte = XOR of all 2*WORD_W/8 data bytes,
//   same handshake; busy stays high until it is accepted. Total bytes per block = 2*WORD_W/8 + 1.
// - Not defined: CSUM state absent; exactly 2*WORD_W/8 bytes per block.
// TESTING
// - Basic: reset, then done with v0=0x41EA3A0A, v1=0x94BAA940, tx_ready=1 -> tx_valid from next cycle,
//   bytes 41 EA 3A 0A 94 BA A9 40 on consecutive cycles, busy drops 1 cycle after last byte.
// - Byte order: MSB_FIRST=0, same data -> bytes 0A 3A EA 41 40 A9 BA 94.
// - Backpressure: tx_ready toggles 0,0,1 repeatedly -> each byte held stable over stall cycles,
//   no byte lost or duplicated, order unchanged.
// - Overrun: second done (v0=0x11111111) 3 cycles after first -> original 8 bytes sent unchanged, overrun=1
//   and stays 1 until reset; done on final handshake cycle also sets overrun.
// - Reset mid-transfer: assert reset after 3rd byte -> tx_valid=0, busy=0, overrun=0 next edge;
//   a following done sends a full fresh block.
// - Checksum (TEA_SER_CHECKSUM_EN): basic data -> 9th byte 0x5C, then busy=0; without macro exactly 8 bytes.

Source files
------------

// File: rtl/tea_out_serializer.sv
// Captures a TEA result block {v0, v1} on done and streams it out byte-wise over valid/ready.
// Define TEA_SER_CHECKSUM_EN to append one XOR checksum byte after the data bytes.
module tea_out_serializer #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [WORD_W-1:0] v0_in,
    input  logic [WORD_W-1:0] v1_in,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned BLK_W  = 2 * WORD_W;
    localparam int unsigned NBYTES = BLK_W / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

`ifdef TEA_SER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM} state_t;
`else
    typedef enum logic {S_IDLE, S_SEND} state_t;
`endif

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [BLK_W-1:0]   blk_c;
`ifdef TEA_SER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    // Reorders a word so its first-to-send byte sits in the top lane.
    function automatic logic [WORD_W-1:0] order_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = w;
        if (MSB_FIRST == 0) begin
            for (int i = 0; i < int'(WORD_W / 8); i++) begin
                r[8*i +: 8] = w[WORD_W - 8 - 8*i +: 8];
            end
        end
        return r;
    endfunction

    assign blk_c = {order_word(v0_in), order_word(v1_in)};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q | (done & busy_q);
`ifdef TEA_SER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (done) begin
                    tx_data_d  = blk_c[BLK_W-1 -: 8];
                    shreg_d    = blk_c << 8;
                    cnt_d      = CNT_W'(NBYTES);
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_SEND;
`ifdef TEA_SER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            S_SEND: begin
                if (tx_ready) begin
`ifdef TEA_SER_CHECKSUM_EN
                    csum_d = csum_q ^ tx_data_q;
`endif
                    if (cnt_q == CNT_W'(1)) begin
`ifdef TEA_SER_CHECKSUM_EN
                        tx_data_d  = csum_q ^ tx_data_q;
                        state_d    = S_CSUM;
`else
                        tx_data_d  = 8'h00;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        tx_data_d = shreg_q[BLK_W-1 -: 8];
                        shreg_d   = shreg_q << 8;
                        cnt_d     = cnt_q - CNT_W'(1);
                    end
                end
            end
`ifdef TEA_SER_CHECKSUM_EN
            S_CSUM: begin
                if (tx_ready) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef TEA_SER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
`ifdef TEA_SER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule
